// File: rtl/simple_fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time for a burst of up
// to MAX_BURST beats and steers its data onto a shared FIFO's write port.
module simple_fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 256,
  parameter int MAX_BURST = 4,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_we,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_full,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;
  logic           found;
  logic           beat;
  logic [IDW-1:0] rr_after;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rr_after = IDW'((int'(grant_q) + 1) % NUM_REQ);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    req_ready   = '0;
    fifo_we     = 1'b0;
    beat        = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        beat = req_valid[grant_q] & ~fifo_full;
        if (!req_valid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = rr_after;
        end else if (beat) begin
          req_ready[grant_q] = 1'b1;
          fifo_we            = 1'b1;
          if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = rr_after;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // No handshake may escape while reset is held, even mid-burst.
    if (!reset) begin
      req_ready = '0;
      fifo_we   = 1'b0;
    end
  end

  assign fifo_din = req_data[int'(grant_q)*WIDTH +: WIDTH];
  assign grant_id = grant_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_simple_fifo_wr_arbiter.sv
// Bench for simple_fifo_wr_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_simple_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_we;
  logic [W-1:0]    fifo_din;
  logic            fifo_full;
  logic [1:0]      grant_id;
  logic            busy;

  simple_fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_we(fifo_we), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus state: each requester offers word {id, seq} until seq reaches target.
  int   seq    [NR];
  int   target [NR];
  logic rand_mode  = 1'b0;
  logic force_full = 1'b0;
  logic chk_en     = 1'b0;

  // Behavioural model: who owns the FIFO, beats written so far, next start point.
  logic m_busy  = 1'b0;
  int   m_owner = 0;
  int   m_beats = 0;
  int   m_ptr   = 0;

  // Observations of the DUT for the directed literal checks.
  logic [W-1:0] dut_fifo [$];
  int           we_cyc   [$];
  int           b_gid    [$];
  int           b_len    [$];
  int           stalls    = 0;
  int           cyc       = 0;
  int           run_beats = 0;
  logic         prev_busy = 1'b0;
  int           prev_gid  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int id, input int s);
    return {8'(id), 24'(s)};
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) begin
      seq[i]    = 0;
      target[i] = 0;
    end
  end

  // Compare process: check outputs against the model, then advance the model.
  initial begin
    logic [NR-1:0] e_ready;
    logic          e_we;
    logic [W-1:0]  e_din;
    bit            found;
    forever begin
      @(negedge clk);
      cyc++;
      e_ready = '0;
      e_we    = 1'b0;
      e_din   = '0;
      if (reset && m_busy && req_valid[m_owner] && !fifo_full) begin
        e_we             = 1'b1;
        e_ready[m_owner] = 1'b1;
        e_din            = word(m_owner, seq[m_owner]);
      end
      if (chk_en) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_id", 64'(grant_id), 64'(m_owner));
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("fifo_we", 64'(fifo_we), 64'(e_we));
        if (e_we) chk("fifo_din", 64'(fifo_din), 64'(e_din));

        if (fifo_we === 1'b1) begin
          dut_fifo.push_back(fifo_din);
          we_cyc.push_back(cyc);
        end
        if (busy === 1'b1 && fifo_we === 1'b1) run_beats++;
        if (busy === 1'b1 && fifo_full === 1'b1 && fifo_we === 1'b0) stalls++;
        if (busy === 1'b0 && prev_busy) begin
          b_gid.push_back(prev_gid);
          b_len.push_back(run_beats);
          run_beats = 0;
        end
        prev_busy = (busy === 1'b1);
        prev_gid  = int'(grant_id);
      end

      if (!reset) begin
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
      end else if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          if (!found && req_valid[(m_ptr + k) % NR]) begin
            found   = 1'b1;
            m_owner = (m_ptr + k) % NR;
          end
        end
        if (found) begin
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end else if (e_we) begin
        seq[m_owner]++;
        m_beats++;
        if (m_beats == MB) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NR;
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NR;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]     = rand_mode ? ($urandom_range(0, 3) != 0) : (target[i] > seq[i]);
      req_data[i*W +: W] = word(i, seq[i]);
    end
    fifo_full = rand_mode ? ($urandom_range(0, 3) == 0) : force_full;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive();
    step();
    step();
    reset = 1'b1;
    drive();
  endtask

  task automatic wait_done(input string nm, input int budget);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      done = !m_busy;
      for (int i = 0; i < NR; i++) if (seq[i] < target[i]) done = 1'b0;
      if (!done) begin
        step();
        n++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles", nm, budget);
    end
    step();
    step();
  endtask

  task automatic wait_beats(input string nm, input int base, input int cnt);
    int n = 0;
    while (dut_fifo.size() - base < cnt && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (dut_fifo.size() - base < cnt) begin
      errors++;
      $display("FAIL %s: only %0d beats seen", nm, dut_fifo.size() - base);
    end
  endtask

  int fb, bb, sb;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive();
    step();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset grant_id", 64'(grant_id), 64'd0);
    chk("reset fifo_we", 64'(fifo_we), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    reset = 1'b1;
    drive();

    // 1: req0 alone, 10 beats -> bursts 4,4,2 with one idle cycle between.
    fb = dut_fifo.size(); bb = b_len.size();
    target[0] = seq[0] + 10;
    drive();
    wait_done("t1 done", 100);
    chk("t1 beats", 64'(dut_fifo.size() - fb), 64'd10);
    for (int k = 0; k < 10; k++) chk("t1 data", 64'(dut_fifo[fb + k]), 64'(k));
    chk("t1 bursts", 64'(b_len.size() - bb), 64'd3);
    chk("t1 len0", 64'(b_len[bb]), 64'd4);
    chk("t1 len1", 64'(b_len[bb + 1]), 64'd4);
    chk("t1 len2", 64'(b_len[bb + 2]), 64'd2);
    chk("t1 gid", 64'(b_gid[bb] + b_gid[bb + 1] + b_gid[bb + 2]), 64'd0);
    chk("t1 span", 64'(we_cyc[fb + 9] - we_cyc[fb]), 64'd11);

    // 2: all four continuously valid -> 0,1,2,3,0,1,2,3, four beats each.
    do_reset();
    fb = dut_fifo.size(); bb = b_len.size();
    for (int i = 0; i < NR; i++) target[i] = seq[i] + 8;
    drive();
    wait_done("t2 done", 200);
    chk("t2 bursts", 64'(b_len.size() - bb), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("t2 gid", 64'(b_gid[bb + k]), 64'(k % 4));
      chk("t2 len", 64'(b_len[bb + k]), 64'd4);
    end
    chk("t2 span", 64'(we_cyc[fb + 31] - we_cyc[fb]), 64'd38);

    // 3: FIFO full for three cycles after beat 2 -> burst still totals 4 beats.
    do_reset();
    fb = dut_fifo.size(); bb = b_len.size(); sb = stalls;
    target[0] = seq[0] + 4;
    drive();
    wait_beats("t3 beat2", fb, 2);
    force_full = 1'b1;
    drive();
    step();
    step();
    force_full = 1'b0;
    wait_done("t3 done", 100);
    chk("t3 stalls", 64'(stalls - sb), 64'd3);
    chk("t3 bursts", 64'(b_len.size() - bb), 64'd1);
    chk("t3 len", 64'(b_len[bb]), 64'd4);
    chk("t3 span", 64'(we_cyc[fb + 3] - we_cyc[fb]), 64'd6);

    // 4: req2 drops after one beat -> req3 beats req1 to the next grant.
    do_reset();
    bb = b_len.size(); fb = dut_fifo.size();
    target[2] = seq[2] + 1;
    drive();
    wait_beats("t4 beat1", fb, 1);
    target[1] = seq[1] + 2;
    target[3] = seq[3] + 2;
    drive();
    wait_done("t4 done", 100);
    chk("t4 bursts", 64'(b_len.size() - bb), 64'd3);
    chk("t4 gid0", 64'(b_gid[bb]), 64'd2);
    chk("t4 len0", 64'(b_len[bb]), 64'd1);
    chk("t4 gid1", 64'(b_gid[bb + 1]), 64'd3);
    chk("t4 gid2", 64'(b_gid[bb + 2]), 64'd1);

    // 5: reset during beat 3 of req1 -> burst abandoned, req0 wins afterwards.
    do_reset();
    bb = b_len.size(); fb = dut_fifo.size();
    target[1] = seq[1] + 4;
    drive();
    wait_beats("t5 beat2", fb, 2);
    reset = 1'b0;
    drive();
    #1;
    chk("t5 we in reset", 64'(fifo_we), 64'd0);
    step();
    chk("t5 busy after reset", 64'(busy), 64'd0);
    step();
    reset = 1'b1;
    target[0] = seq[0] + 1;
    drive();
    wait_done("t5 done", 100);
    chk("t5 bursts", 64'(b_len.size() - bb), 64'd3);
    chk("t5 len0", 64'(b_len[bb]), 64'd2);
    chk("t5 gid1", 64'(b_gid[bb + 1]), 64'd0);
    chk("t5 gid2", 64'(b_gid[bb + 2]), 64'd1);
    chk("t5 len2", 64'(b_len[bb + 2]), 64'd2);

    // 6: pointer at 3 with only req0/req1 valid -> wrap to req0 first.
    do_reset();
    bb = b_len.size();
    target[2] = seq[2] + 1;
    drive();
    wait_done("t6 first", 100);
    target[0] = seq[0] + 1;
    target[1] = seq[1] + 1;
    drive();
    wait_done("t6 done", 100);
    chk("t6 bursts", 64'(b_len.size() - bb), 64'd3);
    chk("t6 gid1", 64'(b_gid[bb + 1]), 64'd0);
    chk("t6 gid2", 64'(b_gid[bb + 2]), 64'd1);

    // Random traffic and back-pressure, checked by the model each cycle.
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        drive();
        step();
        reset = 1'b1;
        drive();
      end
    end
    rand_mode = 1'b0;
    for (int i = 0; i < NR; i++) target[i] = seq[i];
    drive();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
